// File: rtl/alu_operand_sequencer_if.sv
// Operand/opcode bus between the sequencer (master) and the combinational ALU (slave).
interface alu_operand_sequencer_if;
    logic [2:0] ain;
    logic [2:0] bin;
    logic       fun_sel0;
    logic       fun_sel1;
    logic [2:0] alu_out;

    modport master (
        output ain,
        output bin,
        output fun_sel0,
        output fun_sel1,
        input  alu_out
    );

    modport slave (
        input  ain,
        input  bin,
        input  fun_sel0,
        input  fun_sel1,
        output alu_out
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand entry sequencer for the 3-bit ALU: debounced enter/clear buttons,
// A -> B -> opcode entry, settle wait, registered result capture.

// Button conditioner: 2-flop synchronizer, debounce counter, single press pulse.
// After reset the conditioner stays disarmed until the button has been seen
// debounced-low for DEBOUNCE_CYCLES, so a button held through reset never
// turns into a press once reset is released.
module alu_operand_sequencer_btn #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        db_q;
    logic        db_prev_q;
    logic        armed_q;
    logic [15:0] cnt_q;
    logic [15:0] arm_cnt_q;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a level change only after it has persisted for DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            db_prev_q <= db_q;
            if (sync2_q != db_q) begin
                if (cnt_q == DB_LAST) begin
                    db_q  <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Arm press detection once a debounced release has been observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
        end else if (!armed_q) begin
            if (!sync2_q && !db_q) begin
                if (arm_cnt_q == DB_LAST) begin
                    armed_q   <= 1'b1;
                    arm_cnt_q <= '0;
                end else begin
                    arm_cnt_q <= arm_cnt_q + 16'd1;
                end
            end else begin
                arm_cnt_q <= '0;
            end
        end
    end

    assign press_o = armed_q & db_q & ~db_prev_q;
endmodule

module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    sw,
    input  logic                          btn_enter,
    input  logic                          btn_clear,
    alu_operand_sequencer_if.master       alu,
    output logic [2:0]                    result,
    output logic                          result_valid,
    output logic [2:0]                    step
);
    // state  | meaning
    // S_A    | waiting for operand A entry
    // S_B    | waiting for operand B entry
    // S_OP   | waiting for opcode entry
    // S_EXEC | operands held, waiting for the ALU to settle
    // S_SHOW | result captured and valid, waiting for enter to restart
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  ain_q;
    logic [2:0]  bin_q;
    logic [1:0]  fun_q;
    logic [2:0]  result_q;
    logic        valid_q;
    logic [2:0]  step_q;
    logic [15:0] settle_q;
    logic        enter_pulse;
    logic        clear_pulse;

    alu_operand_sequencer_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_enter (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_enter),
        .press_o (enter_pulse)
    );

    alu_operand_sequencer_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_clear),
        .press_o (clear_pulse)
    );

    // Entry sequence; clear takes priority over enter and over a pending capture.
    always_ff @(posedge clk) begin
        if (rst || clear_pulse) begin
            state_q  <= S_A;
            ain_q    <= '0;
            bin_q    <= '0;
            fun_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            step_q   <= 3'b001;
            settle_q <= '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (enter_pulse) begin
                        ain_q   <= sw;
                        state_q <= S_B;
                        step_q  <= 3'b010;
                    end
                end
                S_B: begin
                    if (enter_pulse) begin
                        bin_q   <= sw;
                        state_q <= S_OP;
                        step_q  <= 3'b100;
                    end
                end
                S_OP: begin
                    if (enter_pulse) begin
                        fun_q    <= sw[1:0];
                        settle_q <= SETTLE_LOAD;
                        state_q  <= S_EXEC;
                        step_q   <= 3'b000;
                    end
                end
                S_EXEC: begin
                    if (settle_q == 16'd0) begin
                        result_q <= alu.alu_out;
                        valid_q  <= 1'b1;
                        state_q  <= S_SHOW;
                    end else begin
                        settle_q <= settle_q - 16'd1;
                    end
                end
                S_SHOW: begin
                    if (enter_pulse) begin
                        valid_q <= 1'b0;
                        state_q <= S_A;
                        step_q  <= 3'b001;
                    end
                end
                default: begin
                    state_q <= S_A;
                    step_q  <= 3'b001;
                end
            endcase
        end
    end

    assign alu.ain      = ain_q;
    assign alu.bin      = bin_q;
    assign alu.fun_sel0 = fun_q[0];
    assign alu.fun_sel1 = fun_q[1];
    assign result       = result_q;
    assign result_valid = valid_q;
    assign step         = step_q;
endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end sequencer that drives the combinational 3-bit ALU from board switches and a push-button. The operator enters operand A, then operand B, then the opcode. The block then holds the operands on the ALU inputs, waits for them to settle, and captures the ALU result into a registered, valid-flagged output for the display path. It sits between the board I/O (switches, buttons) and the ALU's `ain`/`bin`/`fun_sel` inputs. It is the initiator side of the ALU interface.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a button level change; legal range 2..65535.
- `SETTLE_CYCLES`, default 1: cycles the block waits in `S_EXEC` before sampling `alu_out`; minimum 1.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  3  value switches; sampled on an accepted enter press.
- `btn_enter`  in  1  raw enter button, active-high, asynchronous to `clk`.
- `btn_clear`  in  1  raw clear button, active-high, asynchronous to `clk`.
- `alu_out`  in  3  ALU result.
- `ain`  out  3  operand A to the ALU (registered).
- `bin`  out  3  operand B to the ALU (registered).
- `fun_sel0`  out  1  opcode bit 0 (registered).
- `fun_sel1`  out  1  opcode bit 1 (registered).
- `result`  out  3  captured ALU result (registered).
- `result_valid`  out  1  high while `result` holds a capture for the current operands.
- `step`  out  3  one-hot entry step for LEDs: 001 = A, 010 = B, 100 = opcode; 000 in `S_EXEC`/`S_SHOW`.

## Operation

Button conditioning, identical for each button:
- Two-flop synchronizer, followed by a debounce counter and a debounced level `db`.
- When synced level ≠ `db`: counter increments each cycle. When it reaches `DEBOUNCE_CYCLES-1` and the level still differs, `db` takes the synced level and the counter clears.
- When synced level = `db`: counter clears. Glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- A press is a 0→1 transition of `db` and yields exactly one internal pulse. Release produces nothing.

FSM states:
- `S_A`: on enter pulse, `ain <= sw`, go to `S_B`.
- `S_B`: on enter pulse, `bin <= sw`, go to `S_OP`.
- `S_OP`: on enter pulse, `{fun_sel1,fun_sel0} <= sw[1:0]` (`sw[2]` ignored), load the settle counter, go to `S_EXEC`.
- `S_EXEC`: ignore enter. After `SETTLE_CYCLES` cycles, `result <= alu_out`, `result_valid <= 1`, go to `S_SHOW`.
- `S_SHOW`: on enter pulse, `result_valid <= 0`, go to `S_A`. `ain`/`bin`/`fun_sel*` keep their values until overwritten.

Opcode map (`{fun_sel1,fun_sel0}`): 00 add, 01 sub, 10 xor, 11 shift-left-by-1.

Clear and reset behaviour:
- A clear pulse in any state goes to `S_A` and zeroes `ain`, `bin`, `fun_sel*`, `result` and `result_valid`.
- Clear wins over an enter pulse in the same cycle.
- Reset, in any state including mid-debounce or mid-`S_EXEC`, returns to `S_A` with all outputs 0 and `step` = 001. It also zeroes the synchronizers, `db` and all counters.

Result arithmetic: `result` is a 3-bit modulo-8 value exactly as returned by the ALU. The block performs no arithmetic itself.

## Timing

- Reset values: `ain` = `bin` = 0, `fun_sel0` = `fun_sel1` = 0, `result` = 0, `result_valid` = 0, `step` = 001, state `S_A`.
- Press latency, counting the first edge that samples the raw button high as edge 0 (button held stable): `db` rises at edge `DEBOUNCE_CYCLES+1`. The FSM update is visible after edge `DEBOUNCE_CYCLES+2`.
- A held button produces one pulse only. A new pulse requires a debounced release followed by a debounced press.
- Execute latency: `fun_sel*` become valid after edge N. `result` and `result_valid` update after edge N+`SETTLE_CYCLES`. `S_SHOW` is entered on that same edge.
- `ain`, `bin` and `fun_sel*` are stable throughout `S_EXEC` and `S_SHOW`.
- `sw` is sampled only on the edge the FSM consumes the enter pulse. `sw` changes at other times have no effect.

## Test plan

- Reset then idle: all outputs 0, `step` = 001; `sw` toggling with no button press produces no change.
- Entry A=3, B=2, op=00 (`DEBOUNCE_CYCLES`=4, `SETTLE_CYCLES`=1): `ain`=3, `bin`=2, `result`=5, `result_valid` rises exactly 1 cycle after `fun_sel` loads.
- Wrap and other ops: sub 2−3 gives 7; xor 5^3 gives 6; shift A=6 gives 4. `result_valid` clears on the next enter press.
- Bounce rejection: `btn_enter` pulses of 1..3 cycles (DEBOUNCE=4) leave the state unchanged. A 4-cycle-stable press advances exactly one step, at edge 6 after the first high sample.
- Clear mid-operation: clear during `S_EXEC` returns to `S_A` with all registers 0 and no capture. Enter and clear debounced on the same cycle: clear wins.
- Synchronous reset asserted during `S_SHOW` and mid-debounce: the next cycle matches the reset values, and no spurious pulse follows deassertion while the button is still held.
